fetch_pc_unit: RTL and testbench
================================

# fetch_pc_unit

Parametrised successor to the plain fetch program counter: holds the fetch PC and steps it by a configurable increment. It also arbitrates between trap, return-from-trap, branch and sequential next-PC sources, honours a fetch stall, and latches redirects that arrive while stalled. It captures the exception PC, detects misaligned branch targets, and sits at the head of the sail-core fetch stage, feeding instruction-memory address and the pipeline flush logic.

## Interface
- XLEN, 32: PC / address width.
- RESET_VAL, 0: PC value after reset.
- TRAP_VEC, 32'h0000_0010: trap handler address (XLEN bits).
- STEP, 4: sequential increment in bytes.
- ALIGN_BITS, 2: low target bits that must be zero; 0 disables the misalign check.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- stall_i  in  1  hold PC; branch/mret requests are latched, not dropped.
- branch_i  in  1  take branch_target_i.
- branch_target_i  in  XLEN  branch/jump target.
- trap_i  in  1  take trap; overrides stall.
- trap_pc_i  in  XLEN  address of trapping instruction.
- mret_i  in  1  return to epc_o.
- pc_o  out  XLEN  current fetch PC.
- epc_o  out  XLEN  saved exception PC.
- redirect_o  out  1  one-cycle pulse: pc_o changed non-sequentially this cycle (flush younger fetches).
- misalign_o  out  1  one-cycle pulse: misaligned branch target converted to trap.

## Operation
- Internal state: pc, epc, pending-valid, pending-kind (BRANCH or MRET), pending-target, two-state FSM RUN / HELD (HELD ⇔ pending-valid).
- Source priority, highest first: trap_i, misaligned branch, mret_i (live or pending), branch_i (live or pending), sequential.
- trap_i: pc ← TRAP_VEC, epc ← trap_pc_i, pending cleared, FSM → RUN, redirect_o=1. Applies regardless of stall_i.
- Misaligned branch (branch_i=1, ALIGN_BITS>0, branch_target_i[ALIGN_BITS-1:0]≠0, no trap_i): treated as trap. pc ← TRAP_VEC, epc ← branch_target_i, misalign_o=1, redirect_o=1, pending cleared. This applies even when stalled.
- RUN, stall_i=0: mret → pc ← epc; branch → pc ← target; else pc ← pc + STEP modulo 2^XLEN (wraps silently).
- RUN, stall_i=1: pc holds. A live mret or aligned branch is stored as pending and FSM → HELD. mret wins if both are asserted; an mret pending stores epc at the time of latching.
- HELD, stall_i=1: pc holds. A new live request replaces the pending one only if its priority is ≥ the pending kind, so a later branch cannot overwrite a pending mret.
- HELD, stall_i=0: a live request replaces pending under the same rule. pc ← the resulting target, pending cleared, FSM → RUN, redirect_o=1.
- epc changes only on trap or misalign.

## Timing
- Reset (async assert, any time): pc_o=RESET_VAL, epc_o=0, pending cleared, FSM=RUN, redirect_o=0, misalign_o=0. Reset mid-HELD discards the pending redirect.
- Reset deassertion: the first rising edge with rst=0 performs the normal next-PC update.
- Latency: a request sampled at edge N is visible on pc_o after edge N, i.e. in cycle N+1. redirect_o/misalign_o are registered and asserted in that same cycle for exactly one cycle.
- A redirect during stall becomes visible in the cycle after the first edge with stall_i=0, with no bubble and no lost request.
- redirect_o and misalign_o never assert during reset. misalign_o=1 implies redirect_o=1.

## Test plan
- Reset/sequential: assert rst mid-cycle → pc_o=0 immediately. Release, run 3 edges → pc_o 0,4,8,12. With XLEN=32, RESET_VAL=32'hFFFF_FFFC → wraps to 0 after one edge.
- Branch: at pc=8, branch_i=1, target=32'h100 → pc_o=32'h100 next cycle, redirect_o one-cycle pulse, then 32'h104.
- Stalled branch: stall_i=1 for 3 cycles, branch to 32'h200 pulsed in the first → pc_o held. Release stall → pc_o=32'h200 one edge later, redirect_o pulse.
- Trap and return: trap_i=1, trap_pc_i=32'h40 while stall_i=1 → pc_o=32'h10, epc_o=32'h40. Later mret_i=1 → pc_o=32'h40.
- Priority: same edge trap_i, mret_i, branch_i → trap taken. During stall, pending mret followed by branch to 32'h300 → on release pc_o=epc_o, not 32'h300.
- Misalign: branch_i=1, target=32'h102 → pc_o=32'h10, epc_o=32'h102, misalign_o and redirect_o pulse once. Set ALIGN_BITS=0 → pc_o=32'h102, no pulse on misalign_o.

Source files
------------

// File: rtl/fetch_pc_unit.sv
// Fetch PC with trap/mret/branch/sequential arbitration, stall-held redirects and
// misaligned-target trapping; redirect/misalign flags are registered one-cycle pulses.
module fetch_pc_unit #(
  parameter int unsigned        XLEN       = 32,
  parameter logic [XLEN-1:0]    RESET_VAL  = '0,
  parameter logic [XLEN-1:0]    TRAP_VEC   = XLEN'(32'h0000_0010),
  parameter int unsigned        STEP       = 4,
  parameter int unsigned        ALIGN_BITS = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall_i,
  input  logic            branch_i,
  input  logic [XLEN-1:0] branch_target_i,
  input  logic            trap_i,
  input  logic [XLEN-1:0] trap_pc_i,
  input  logic            mret_i,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] epc_o,
  output logic            redirect_o,
  output logic            misalign_o
);

  typedef enum logic [0:0] {RUN = 1'b0, HELD = 1'b1} state_e;

  localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'((64'd1 << ALIGN_BITS) - 64'd1);
  localparam logic [XLEN-1:0] STEP_V     = XLEN'(STEP);

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] epc_q, epc_d;
  logic            pend_mret_q, pend_mret_d;
  logic [XLEN-1:0] pend_tgt_q, pend_tgt_d;
  logic            redirect_q, redirect_d;
  logic            misalign_q, misalign_d;

  logic            misal;
  logic            live_vld;
  logic [XLEN-1:0] live_tgt;
  logic            take_live;
  logic            sel_vld;
  logic            sel_mret;
  logic [XLEN-1:0] sel_tgt;

  always_comb begin
    misal     = branch_i && ((branch_target_i & ALIGN_MASK) != '0);
    live_vld  = mret_i || branch_i;
    live_tgt  = mret_i ? epc_q : branch_target_i;
    // A live request displaces a pending one unless it would demote a pending mret.
    take_live = live_vld && (state_q == RUN || mret_i || !pend_mret_q);
    sel_vld   = (state_q == HELD) || live_vld;
    sel_mret  = take_live ? mret_i   : pend_mret_q;
    sel_tgt   = take_live ? live_tgt : pend_tgt_q;

    pc_d        = pc_q;
    epc_d       = epc_q;
    pend_mret_d = pend_mret_q;
    pend_tgt_d  = pend_tgt_q;
    state_d     = state_q;
    redirect_d  = 1'b0;
    misalign_d  = 1'b0;

    if (trap_i) begin
      pc_d       = TRAP_VEC;
      epc_d      = trap_pc_i;
      state_d    = RUN;
      redirect_d = 1'b1;
    end else if (misal) begin
      pc_d       = TRAP_VEC;
      epc_d      = branch_target_i;
      state_d    = RUN;
      redirect_d = 1'b1;
      misalign_d = 1'b1;
    end else if (stall_i) begin
      if (sel_vld) begin
        state_d     = HELD;
        pend_mret_d = sel_mret;
        pend_tgt_d  = sel_tgt;
      end
    end else begin
      state_d = RUN;
      if (sel_vld) begin
        pc_d       = sel_tgt;
        redirect_d = 1'b1;
      end else begin
        pc_d = pc_q + STEP_V;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= RUN;
      pc_q        <= RESET_VAL;
      epc_q       <= '0;
      pend_mret_q <= 1'b0;
      pend_tgt_q  <= '0;
      redirect_q  <= 1'b0;
      misalign_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      epc_q       <= epc_d;
      pend_mret_q <= pend_mret_d;
      pend_tgt_q  <= pend_tgt_d;
      redirect_q  <= redirect_d;
      misalign_q  <= misalign_d;
    end
  end

  assign pc_o       = pc_q;
  assign epc_o      = epc_q;
  assign redirect_o = redirect_q;
  assign misalign_o = misalign_q;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Bench for fetch_pc_unit: three configurations (default, wrapping reset value,
// misalign check disabled) driven in lockstep and compared to a request-level model.
module tb_fetch_pc_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall_i = 1'b0;
  logic        branch_i = 1'b0;
  logic [31:0] branch_target_i = '0;
  logic        trap_i = 1'b0;
  logic [31:0] trap_pc_i = '0;
  logic        mret_i = 1'b0;

  logic [31:0] pc_w  [3];
  logic [31:0] epc_w [3];
  logic        red_w [3];
  logic        mis_w [3];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fetch_pc_unit u_dut0 (
    .clk(clk), .rst(rst), .stall_i(stall_i), .branch_i(branch_i),
    .branch_target_i(branch_target_i), .trap_i(trap_i), .trap_pc_i(trap_pc_i),
    .mret_i(mret_i), .pc_o(pc_w[0]), .epc_o(epc_w[0]),
    .redirect_o(red_w[0]), .misalign_o(mis_w[0]));

  fetch_pc_unit #(.RESET_VAL(32'hFFFF_FFFC)) u_dut1 (
    .clk(clk), .rst(rst), .stall_i(stall_i), .branch_i(branch_i),
    .branch_target_i(branch_target_i), .trap_i(trap_i), .trap_pc_i(trap_pc_i),
    .mret_i(mret_i), .pc_o(pc_w[1]), .epc_o(epc_w[1]),
    .redirect_o(red_w[1]), .misalign_o(mis_w[1]));

  fetch_pc_unit #(.ALIGN_BITS(0)) u_dut2 (
    .clk(clk), .rst(rst), .stall_i(stall_i), .branch_i(branch_i),
    .branch_target_i(branch_target_i), .trap_i(trap_i), .trap_pc_i(trap_pc_i),
    .mret_i(mret_i), .pc_o(pc_w[2]), .epc_o(epc_w[2]),
    .redirect_o(red_w[2]), .misalign_o(mis_w[2]));

  // Model state: pending kind 0 = none, 1 = branch, 2 = mret (higher wins).
  logic [31:0] m_pc  [3];
  logic [31:0] m_epc [3];
  int          m_pk  [3];
  logic [31:0] m_pt  [3];
  bit          m_red [3];
  bit          m_mis [3];

  function automatic logic [31:0] reset_of(input int d);
    return (d == 1) ? 32'hFFFF_FFFC : 32'h0;
  endfunction

  function automatic int align_of(input int d);
    return (d == 2) ? 0 : 2;
  endfunction

  task automatic model_reset(input int d);
    m_pc[d]  = reset_of(d);
    m_epc[d] = 32'h0;
    m_pk[d]  = 0;
    m_pt[d]  = 32'h0;
    m_red[d] = 1'b0;
    m_mis[d] = 1'b0;
  endtask

  task automatic model_step(input int d);
    bit          bad;
    int          lk;
    logic [31:0] lt;
    m_red[d] = 1'b0;
    m_mis[d] = 1'b0;
    bad = branch_i && ((branch_target_i % (32'd1 << align_of(d))) != 32'd0);
    if (trap_i) begin
      m_pc[d] = 32'h10; m_epc[d] = trap_pc_i; m_pk[d] = 0; m_red[d] = 1'b1;
    end else if (bad) begin
      m_pc[d] = 32'h10; m_epc[d] = branch_target_i; m_pk[d] = 0;
      m_red[d] = 1'b1; m_mis[d] = 1'b1;
    end else begin
      lk = mret_i ? 2 : (branch_i ? 1 : 0);
      lt = mret_i ? m_epc[d] : branch_target_i;
      if (lk != 0 && lk >= m_pk[d]) begin
        m_pk[d] = lk;
        m_pt[d] = lt;
      end
      if (!stall_i) begin
        if (m_pk[d] != 0) begin
          m_pc[d]  = m_pt[d];
          m_red[d] = 1'b1;
        end else begin
          m_pc[d] = m_pc[d] + 32'd4;
        end
        m_pk[d] = 0;
      end
    end
  endtask

  always @(posedge clk or posedge rst) begin
    for (int d = 0; d < 3; d++) begin
      if (rst) model_reset(d);
      else     model_step(d);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      check($sformatf("pc[%0d]", d),  pc_w[d],  m_pc[d]);
      check($sformatf("epc[%0d]", d), epc_w[d], m_epc[d]);
      check($sformatf("redirect[%0d]", d), 32'(red_w[d]), 32'(m_red[d]));
      check($sformatf("misalign[%0d]", d), 32'(mis_w[d]), 32'(m_mis[d]));
    end
  end

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic clr();
    stall_i = 1'b0; branch_i = 1'b0; trap_i = 1'b0; mret_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    #12;
    check("reset pc", pc_w[0], 32'h0);
    check("reset redirect", 32'(red_w[0]), 32'h0);
    rst = 1'b0;
    cyc(); check("seq pc 4", pc_w[0], 32'h4);
    cyc(); check("seq pc 8", pc_w[0], 32'h8);

    // Asynchronous reset in the middle of a cycle.
    @(posedge clk); #2 rst = 1'b1; #1;
    check("async rst pc0", pc_w[0], 32'h0);
    check("async rst pc1", pc_w[1], 32'hFFFF_FFFC);
    @(negedge clk); #1 rst = 1'b0;
    cyc(); check("seq after rst", pc_w[0], 32'h4);
    check("wrap pc1", pc_w[1], 32'h0);
    cyc(); check("seq pc 8 again", pc_w[0], 32'h8);

    // Plain branch.
    branch_i = 1'b1; branch_target_i = 32'h100;
    cyc(); check("branch pc", pc_w[0], 32'h100);
    check("branch redirect", 32'(red_w[0]), 32'h1);
    clr();
    cyc(); check("after branch pc", pc_w[0], 32'h104);
    check("redirect drops", 32'(red_w[0]), 32'h0);

    // Branch during a 3-cycle stall.
    stall_i = 1'b1; branch_i = 1'b1; branch_target_i = 32'h200;
    cyc(); branch_i = 1'b0;
    cyc(); cyc(); check("stall hold", pc_w[0], 32'h104);
    stall_i = 1'b0;
    cyc(); check("held branch pc", pc_w[0], 32'h200);
    check("held branch redirect", 32'(red_w[0]), 32'h1);
    cyc();

    // Trap overrides stall, then return.
    stall_i = 1'b1; trap_i = 1'b1; trap_pc_i = 32'h40;
    cyc(); check("trap pc", pc_w[0], 32'h10);
    check("trap epc", epc_w[0], 32'h40);
    clr();
    cyc();
    mret_i = 1'b1;
    cyc(); check("mret pc", pc_w[0], 32'h40);
    clr();
    cyc();

    // Trap beats mret and branch on the same edge.
    trap_i = 1'b1; trap_pc_i = 32'h80; mret_i = 1'b1; branch_i = 1'b1; branch_target_i = 32'h100;
    cyc(); check("prio trap pc", pc_w[0], 32'h10);
    check("prio trap epc", epc_w[0], 32'h80);
    clr();
    cyc();

    // Pending mret is not displaced by a later branch.
    stall_i = 1'b1; mret_i = 1'b1;
    cyc(); mret_i = 1'b0; branch_i = 1'b1; branch_target_i = 32'h300;
    cyc(); branch_i = 1'b0; stall_i = 1'b0;
    cyc(); check("pending mret wins", pc_w[0], 32'h80);

    // Pending branch replaced by a later branch, and by an mret on release.
    stall_i = 1'b1; branch_i = 1'b1; branch_target_i = 32'h200;
    cyc(); branch_target_i = 32'h208;
    cyc(); branch_i = 1'b0; stall_i = 1'b0;
    cyc(); check("branch replaces branch", pc_w[0], 32'h208);
    stall_i = 1'b1; branch_i = 1'b1; branch_target_i = 32'h400;
    cyc(); branch_i = 1'b0; stall_i = 1'b0; mret_i = 1'b1;
    cyc(); check("live mret replaces branch", pc_w[0], 32'h80);
    clr();
    cyc();

    // Misaligned branch target.
    branch_i = 1'b1; branch_target_i = 32'h102;
    cyc(); check("misalign pc", pc_w[0], 32'h10);
    check("misalign epc", epc_w[0], 32'h102);
    check("misalign pulse", 32'(mis_w[0]), 32'h1);
    check("no-align pc", pc_w[2], 32'h102);
    check("no-align pulse", 32'(mis_w[2]), 32'h0);
    clr();
    cyc(); check("misalign drops", 32'(mis_w[0]), 32'h0);

    // Misalign while stalled with a pending branch discards the pending branch.
    stall_i = 1'b1; branch_i = 1'b1; branch_target_i = 32'h200;
    cyc(); branch_target_i = 32'h201;
    cyc(); check("stalled misalign epc", epc_w[0], 32'h201);
    branch_i = 1'b0;
    cyc(); stall_i = 1'b0;
    cyc(); check("pending cleared by misalign", pc_w[0], 32'h14);

    // Reset while a redirect is pending.
    stall_i = 1'b1; branch_i = 1'b1; branch_target_i = 32'h200;
    cyc(); branch_i = 1'b0;
    rst = 1'b1; #2 rst = 1'b0;
    stall_i = 1'b0;
    cyc(); check("rst drops pending", pc_w[0], 32'h4);
    check("rst drops redirect", 32'(red_w[0]), 32'h0);
    cyc(); cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
